mem_arbiter: RTL and testbench

- Arbitrates one shared, multi-cycle, single-outstanding memory port between two requesters: the instruction-fetch read port and the data (load/store) port of the pipelined hart.
- Sits between the fetch/memory-access stages and the unified memory model that replaces the combinational imem/dmem in later phases.
- Owns request sequencing, grant, response routing and starvation control.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arb_pick.sv | 40 ++++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, owner tags, fetch byte mask.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam logic [3:0] FULL_MASK = 4'b1111;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Arbitration select: data has priority unless fetch has lost STARVE_LIMIT times in a row.
module mem_arb_pick #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_arb,
    input  logic i_if_req,
    input  logic i_dm_req,
    output logic o_win_if,
    output logic o_win_dm
);

    logic [3:0] r_starve;
    logic       w_force;

    assign w_force = (r_starve == 4'(STARVE_LIMIT));

    always_comb begin
        o_win_if = 1'b0;
        o_win_dm = 1'b0;
        if (i_arb) begin
            if (i_if_req && (w_force || !i_dm_req)) o_win_if = 1'b1;
            else if (i_dm_req)                      o_win_dm = 1'b1;
        end
    end

    // Counter only moves on IDLE cycles; a loss means fetch pending while data wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve <= 4'd0;
        end else if (i_arb) begin
            if (!i_if_req || o_win_if)
                r_starve <= 4'd0;
            else if (o_win_dm && !w_force)
                r_starve <= r_starve + 4'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-outstanding memory port.
// Optional MEM_ARB_PERF_EN adds saturating grant and busy-cycle counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    input  logic        i_dm_req,
    input  logic        i_dm_wen,
    input  logic [31:0] i_dm_addr,
    input  logic [31:0] i_dm_wdata,
    input  logic [3:0]  i_dm_mask,
    output logic        o_dm_gnt,
    output logic        o_dm_rvalid,
    output logic [31:0] o_dm_rdata,
    output logic        o_mem_req,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_err
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] o_perf_if_grants,
    output logic [31:0] o_perf_dm_grants,
    output logic [31:0] o_perf_wait_cycles
`endif
);

    state_t      r_state, w_state_nxt;
    owner_t      r_owner;
    logic        r_if_gnt, r_dm_gnt, r_if_rvalid, r_dm_rvalid;
    logic [31:0] r_if_rdata, r_dm_rdata;
    logic        r_mem_req, r_mem_wen;
    logic [31:0] r_mem_addr, r_mem_wdata;
    logic [3:0]  r_mem_mask;
    logic        r_err;
    logic        w_arb, w_win_if, w_win_dm, w_hs, w_resp;

    assign w_arb = (r_state == IDLE);

    mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_arb    (w_arb),
        .i_if_req (i_if_req),
        .i_dm_req (i_dm_req),
        .o_win_if (w_win_if),
        .o_win_dm (w_win_dm)
    );

    // The grant cycle is spent in REQ with mem_req still low, so the handshake
    // only counts once the request is actually on the bus.
    assign w_hs   = (r_state == REQ) && r_mem_req && i_mem_ready;
    assign w_resp = (r_state == WAIT) && i_mem_rvalid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_win_if || w_win_dm) w_state_nxt = REQ;
            REQ:     if (w_hs)                 w_state_nxt = WAIT;
            WAIT:    if (w_resp)               w_state_nxt = IDLE;
            default:                           w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner     <= OWN_IF;
            r_if_gnt    <= 1'b0;
            r_dm_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_mask  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_if_gnt    <= w_win_if;
            r_dm_gnt    <= w_win_dm;
            r_if_rvalid <= w_resp && (r_owner == OWN_IF);
            r_dm_rvalid <= w_resp && (r_owner == OWN_DM);
            r_mem_req   <= (r_state == REQ) && !w_hs;
            if (w_resp) begin
                if (r_owner == OWN_IF) r_if_rdata <= i_mem_rdata;
                else                   r_dm_rdata <= i_mem_rdata;
            end
            if (w_win_if) begin
                r_owner     <= OWN_IF;
                r_mem_wen   <= 1'b0;
                r_mem_addr  <= {i_if_addr[31:2], 2'b00};
                r_mem_wdata <= '0;
                r_mem_mask  <= FULL_MASK;
            end else if (w_win_dm) begin
                r_owner     <= OWN_DM;
                r_mem_wen   <= i_dm_wen;
                r_mem_addr  <= {i_dm_addr[31:2], 2'b00};
                r_mem_wdata <= i_dm_wdata;
                r_mem_mask  <= i_dm_mask;
            end
            if (i_mem_rvalid && (r_state != WAIT)) r_err <= 1'b1;
        end
    end

    assign o_if_gnt    = r_if_gnt;
    assign o_dm_gnt    = r_dm_gnt;
    assign o_if_rvalid = r_if_rvalid;
    assign o_dm_rvalid = r_dm_rvalid;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_mem_req   = r_mem_req;
    assign o_mem_wen   = r_mem_wen;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_mask  = r_mem_mask;
    assign o_err       = r_err;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_perf_if, r_perf_dm, r_perf_wait;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf_if   <= '0;
            r_perf_dm   <= '0;
            r_perf_wait <= '0;
        end else begin
            if (w_win_if)          r_perf_if   <= sat_inc32(r_perf_if);
            if (w_win_dm)          r_perf_dm   <= sat_inc32(r_perf_dm);
            if (r_state != IDLE)   r_perf_wait <= sat_inc32(r_perf_wait);
        end
    end

    assign o_perf_if_grants   = r_perf_if;
    assign o_perf_dm_grants   = r_perf_dm;
    assign o_perf_wait_cycles = r_perf_wait;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected grants/responses queued by stimulus, popped by a monitor.
module tb_mem_arbiter;

    localparam int K_GNT = 0, K_RV = 1;
    localparam int P_IF = 0, P_DM = 1;

    typedef struct {
        int          kind;
        int          port;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
        int          stall;
        int          rvd;
    } mtx_t;

    logic        i_clk = 1'b0, i_rst_n;
    logic        i_if_req, i_dm_req, i_dm_wen;
    logic [31:0] i_if_addr, i_dm_addr, i_dm_wdata;
    logic [3:0]  i_dm_mask;
    logic        o_if_gnt, o_if_rvalid, o_dm_gnt, o_dm_rvalid;
    logic [31:0] o_if_rdata, o_dm_rdata;
    logic        o_mem_req, o_mem_wen, o_err;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_ready, i_mem_rvalid;
    logic [31:0] i_mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] o_perf_if_grants, o_perf_dm_grants, o_perf_wait_cycles;
`endif

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_dm_req(i_dm_req), .i_dm_wen(i_dm_wen), .i_dm_addr(i_dm_addr),
        .i_dm_wdata(i_dm_wdata), .i_dm_mask(i_dm_mask),
        .o_dm_gnt(o_dm_gnt), .o_dm_rvalid(o_dm_rvalid), .o_dm_rdata(o_dm_rdata),
        .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_err(o_err)
`ifdef MEM_ARB_PERF_EN
        , .o_perf_if_grants(o_perf_if_grants), .o_perf_dm_grants(o_perf_dm_grants),
        .o_perf_wait_cycles(o_perf_wait_cycles)
`endif
    );

    always #5 i_clk = ~i_clk;

    int   n_vec = 0, n_err = 0;
    ev_t  exp_q[$];
    mtx_t mem_q[$];
    int   inj_req = 0, inj_done = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int kind, input int port, input logic [31:0] data);
        ev_t e;
        e.kind = kind; e.port = port; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic push_mem(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] mask, input logic [31:0] rdata,
                            input int stall, input int rvd);
        mtx_t m;
        m.wen = wen; m.addr = addr; m.wdata = wdata; m.mask = mask;
        m.rdata = rdata; m.stall = stall; m.rvd = rvd;
        mem_q.push_back(m);
    endtask

    // Monitor: every grant/response pulse must match the head of the expectation queue.
    task automatic observe(input int kind, input int port, input logic [31:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_pulse: got kind %0d port %0d data %h, expected none", kind, port, data);
        end else begin
            e = exp_q.pop_front();
            check("event_kind_port", 32'(kind * 2 + port), 32'(e.kind * 2 + e.port));
            if (kind == K_RV) check(port == P_IF ? "if_rdata" : "dm_rdata", data, e.data);
        end
    endtask

    initial begin
        forever begin
            @(negedge i_clk);
            if (i_rst_n === 1'b1) begin
                if (o_dm_gnt)    observe(K_GNT, P_DM, 32'd0);
                if (o_if_gnt)    observe(K_GNT, P_IF, 32'd0);
                if (o_dm_rvalid) observe(K_RV,  P_DM, o_dm_rdata);
                if (o_if_rvalid) observe(K_RV,  P_IF, o_if_rdata);
            end
        end
    end

    // Memory model: checks payload every cycle o_mem_req is high, stalls, then answers.
    initial begin
        mtx_t cur;
        bit   busy = 0, waiting = 0;
        int   stall = 0, rvd = 0;
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
        forever begin
            @(negedge i_clk);
            i_mem_ready  = 1'b0;
            i_mem_rvalid = 1'b0;
            if (i_rst_n !== 1'b1) begin
                busy = 0; waiting = 0;
            end else if (inj_req != inj_done) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = 32'h5A5A_5A5A;
                inj_done++;
            end else if (waiting) begin
                if (rvd == 0) begin
                    i_mem_rvalid = 1'b1;
                    i_mem_rdata  = cur.rdata;
                    waiting = 0; busy = 0;
                end else rvd--;
            end else if (o_mem_req) begin
                if (!busy) begin
                    if (mem_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_mem_req: got addr %h, expected no request", o_mem_addr);
                    end else begin
                        cur = mem_q.pop_front();
                        busy = 1; stall = cur.stall;
                    end
                end
                if (busy) begin
                    check("mem_wen",   32'(o_mem_wen),  32'(cur.wen));
                    check("mem_addr",  o_mem_addr,      cur.addr);
                    check("mem_wdata", o_mem_wdata,     cur.wdata);
                    check("mem_mask",  32'(o_mem_mask), 32'(cur.mask));
                    if (stall > 0) stall--;
                    else begin
                        i_mem_ready = 1'b1;
                        waiting = 1; rvd = cur.rvd;
                    end
                end
            end
        end
    end

    task automatic wait_dm_gnt();
        for (int c = 0; c < 60; c++) begin
            @(negedge i_clk);
            if (o_dm_gnt) return;
        end
        n_vec++; n_err++;
        $display("FAIL dm_gnt_timeout: got no o_dm_gnt, expected one within 60 cycles");
    endtask

    task automatic wait_if_gnt();
        for (int c = 0; c < 60; c++) begin
            @(negedge i_clk);
            if (o_if_gnt) return;
        end
        n_vec++; n_err++;
        $display("FAIL if_gnt_timeout: got no o_if_gnt, expected one within 60 cycles");
    endtask

    task automatic dm_go(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask);
        i_dm_wen = wen; i_dm_addr = addr; i_dm_wdata = wdata; i_dm_mask = mask;
        i_dm_req = 1'b1;
        wait_dm_gnt();
        i_dm_req = 1'b0;
    endtask

    task automatic if_go(input logic [31:0] addr);
        i_if_addr = addr;
        i_if_req  = 1'b1;
        wait_if_gnt();
        i_if_req  = 1'b0;
    endtask

    task automatic dm_stream(input int n);
        for (int k = 0; k < n; k++) begin
            i_dm_wen = 1'b0; i_dm_addr = 32'h4000 + 32'(4 * k);
            i_dm_wdata = '0; i_dm_mask = 4'hF;
            i_dm_req = 1'b1;
            wait_dm_gnt();
        end
        i_dm_req = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 100 && (exp_q.size() != 0 || mem_q.size() != 0); c++) @(negedge i_clk);
        check("drain_exp_q", 32'(exp_q.size()), 32'd0);
        check("drain_mem_q", 32'(mem_q.size()), 32'd0);
        repeat (2) @(negedge i_clk);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_if_req = 1'b0; i_if_addr = '0;
        i_dm_req = 1'b0; i_dm_wen = 1'b0; i_dm_addr = '0; i_dm_wdata = '0; i_dm_mask = '0;
        repeat (3) @(negedge i_clk);
        check("rst_mem_req", 32'(o_mem_req), 32'd0);
        check("rst_gnts", 32'({o_if_gnt, o_dm_gnt}), 32'd0);
        check("rst_rvalids", 32'({o_if_rvalid, o_dm_rvalid}), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Fetch only: misaligned address, 4-cycle latency
        push_mem(1'b0, 32'h0000_1004, 32'h0, 4'hF, 32'hDEAD_BEEF, 0, 0);
        push_ev(K_GNT, P_IF, 0); push_ev(K_RV, P_IF, 32'hDEAD_BEEF);
        i_if_addr = 32'h0000_1006; i_if_req = 1'b1;
        @(negedge i_clk);
        check("fetch_gnt_t0", 32'(o_if_gnt), 32'd1);
        i_if_req = 1'b0;
        repeat (3) @(negedge i_clk);
        check("fetch_rvalid_lat4", 32'(o_if_rvalid), 32'd1);
        check("fetch_rdata", o_if_rdata, 32'hDEAD_BEEF);
        repeat (2) @(negedge i_clk);
        check("fetch_rdata_held", o_if_rdata, 32'hDEAD_BEEF);
        drain();

        // Simultaneous: data first
        push_mem(1'b0, 32'h0000_3008, 32'h0, 4'hF, 32'h1111_2222, 0, 0);
        push_mem(1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'h3333_4444, 0, 0);
        push_ev(K_GNT, P_DM, 0); push_ev(K_RV, P_DM, 32'h1111_2222);
        push_ev(K_GNT, P_IF, 0); push_ev(K_RV, P_IF, 32'h3333_4444);
        fork
            dm_go(1'b0, 32'h0000_300A, 32'h0, 4'hF);
            if_go(32'h0000_0100);
        join
        drain();

        // Starvation: 4 data wins, then fetch forced, then last data
        for (int k = 0; k < 4; k++) begin
            push_mem(1'b0, 32'h4000 + 32'(4 * k), 32'h0, 4'hF, 32'hA000_0000 + 32'(k), 0, 0);
            push_ev(K_GNT, P_DM, 0); push_ev(K_RV, P_DM, 32'hA000_0000 + 32'(k));
        end
        push_mem(1'b0, 32'h0000_0200, 32'h0, 4'hF, 32'h0000_F00D, 0, 0);
        push_ev(K_GNT, P_IF, 0); push_ev(K_RV, P_IF, 32'h0000_F00D);
        push_mem(1'b0, 32'h0000_4010, 32'h0, 4'hF, 32'hA000_0004, 0, 0);
        push_ev(K_GNT, P_DM, 0); push_ev(K_RV, P_DM, 32'hA000_0004);
        fork
            if_go(32'h0000_0200);
            dm_stream(5);
        join
        drain();

        // Store byte to lane 3 with 3 stall cycles
        push_mem(1'b1, 32'h0000_2000, 32'hAB00_0000, 4'b1000, 32'hC0DE_0001, 3, 0);
        push_ev(K_GNT, P_DM, 0); push_ev(K_RV, P_DM, 32'hC0DE_0001);
        dm_go(1'b1, 32'h0000_2003, 32'hAB00_0000, 4'b1000);
        drain();

        // Zero-mask store still forwarded and completed
        push_mem(1'b1, 32'h0000_2010, 32'h1234_5678, 4'b0000, 32'hC0DE_0002, 0, 0);
        push_ev(K_GNT, P_DM, 0); push_ev(K_RV, P_DM, 32'hC0DE_0002);
        dm_go(1'b1, 32'h0000_2010, 32'h1234_5678, 4'b0000);
        drain();

        // Reset while in WAIT: transaction dropped, no response afterwards
        push_mem(1'b0, 32'h0000_5000, 32'h0, 4'hF, 32'h7777_7777, 0, 6);
        push_ev(K_GNT, P_DM, 0);
        dm_go(1'b0, 32'h0000_5000, 32'h0, 4'hF);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("rstw_mem_req", 32'(o_mem_req), 32'd0);
        check("rstw_dm_rdata", o_dm_rdata, 32'd0);
        check("rstw_if_rdata", o_if_rdata, 32'd0);
        check("rstw_mem_addr", o_mem_addr, 32'd0);
        check("rstw_mem_mask", 32'(o_mem_mask), 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (12) @(negedge i_clk);
        check("rstw_no_err", 32'(o_err), 32'd0);
        drain();

        // Spurious rvalid in IDLE: sticky error, no response pulse
        inj_req++;
        repeat (4) @(negedge i_clk);
        check("spur_err_set", 32'(o_err), 32'd1);
        repeat (5) @(negedge i_clk);
        check("spur_err_sticky", 32'(o_err), 32'd1);
        drain();
        i_rst_n = 1'b0;
        #1;
        check("spur_err_cleared", 32'(o_err), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
